// File: rtl/chip8_pkg.sv
// Shared CHIP-8 fetch definitions: default address width, reset PC, fetch FSM states
// and the prefetch queue entry layout used at the default address width.
package chip8_pkg;

    localparam int CHIP8_ADDR_W   = 12;
    localparam int CHIP8_PC_RESET = 'h200;

    typedef enum logic [1:0] {
        REQ_HI,
        REQ_LO,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [CHIP8_ADDR_W-1:0] pc;
        logic [15:0]             instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with flush, occupancy level and simultaneous push/pop.
// Flush has priority over push and pop in the same cycle.
module fetch_queue #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_eff, pop_eff;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == (PTR_W+1)'(DEPTH));
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full_o || pop_eff);
    assign level_o  = count_q;
    // Head reads as zero while empty so the consumer-facing outputs are defined after reset.
    assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_store
            always_ff @(posedge clk) begin
                if (push_eff && !flush_i && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_eff && !pop_eff)      count_q <= count_q + (PTR_W+1)'(1);
            else if (pop_eff && !push_eff) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// CHIP-8 instruction prefetcher: byte-wise big-endian fetch into a queue, redirect with drain.
// Optional macro FETCH_TICK_THROTTLE_EN limits hand-over to one instruction per timer_cpu_tick.
module cpu_fetch_unit
    import chip8_pkg::*;
#(
    parameter int                ADDR_W      = CHIP8_ADDR_W,
    parameter logic [ADDR_W-1:0] PC_RESET    = ADDR_W'(CHIP8_PC_RESET),
    parameter int                QUEUE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [15:0]                  instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level,
    input  logic                         timer_cpu_tick,
    output logic                         mem_read,
    output logic [ADDR_W-1:0]            mem_read_addr,
    input  logic [7:0]                   mem_read_data,
    input  logic                         mem_read_ack
);
    localparam int ENTRY_W = ADDR_W + 16;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [7:0]        hi_q, hi_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              push, handshake, q_full, q_empty;
    logic [ENTRY_W-1:0] q_head;

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({fpc_q, hi_q, mem_read_data}),
        .pop_i       (handshake),
        .flush_i     (redirect),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .full_o      (q_full),
        .level_o     (queue_level)
    );

    assign instr         = q_head[15:0];
    assign instr_pc      = q_head[ENTRY_W-1:16];
    assign mem_read      = mem_read_q;
    assign mem_read_addr = addr_q;
    assign handshake     = instr_valid && instr_ready;

`ifdef FETCH_TICK_THROTTLE_EN
    logic credit_q, credit_d;

    assign instr_valid = !q_empty && (timer_cpu_tick || credit_q);
    assign credit_d    = handshake ? 1'b0 : (timer_cpu_tick ? 1'b1 : credit_q);

    always_ff @(posedge clk) begin
        if (rst) credit_q <= 1'b0;
        else     credit_q <= credit_d;
    end
`else
    logic unused_tick;

    assign unused_tick = timer_cpu_tick;
    assign instr_valid = !q_empty;
`endif

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        hi_d       = hi_q;
        mem_read_d = mem_read_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            REQ_HI: begin
                if (mem_read_q) begin
                    if (mem_read_ack) begin
                        hi_d       = mem_read_data;
                        mem_read_d = 1'b0;
                        state_d    = REQ_LO;
                    end
                end else if (!q_full) begin
                    mem_read_d = 1'b1;
                    addr_d     = fpc_q;
                end
            end
            REQ_LO: begin
                if (mem_read_q) begin
                    if (mem_read_ack) begin
                        push       = 1'b1;
                        mem_read_d = 1'b0;
                        fpc_d      = fpc_q + ADDR_W'(2);
                        state_d    = REQ_HI;
                    end
                end else begin
                    mem_read_d = 1'b1;
                    addr_d     = fpc_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (mem_read_ack) begin
                    mem_read_d = 1'b0;
                    state_d    = REQ_HI;
                end
            end
            default: state_d = REQ_HI;
        endcase
        // A read completing in the redirect cycle needs no drain; otherwise keep it open until its ack.
        if (redirect) begin
            push   = 1'b0;
            fpc_d  = redirect_pc;
            addr_d = addr_q;
            if (mem_read_q && !mem_read_ack) begin
                state_d    = DRAIN;
                mem_read_d = 1'b1;
            end else begin
                state_d    = REQ_HI;
                mem_read_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REQ_HI;
            fpc_q      <= PC_RESET;
            hi_q       <= '0;
            mem_read_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            hi_q       <= hi_d;
            mem_read_q <= mem_read_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: stream model (entries follow sequentially from the last
// redirect target, bytes taken from the bench memory) plus literal expectations per scenario.
module tb_cpu_fetch_unit;
    import chip8_pkg::*;

    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [2:0]    queue_level;
    logic          timer_cpu_tick = 1'b1;
    logic          mem_read;
    logic [AW-1:0] mem_read_addr;
    logic [7:0]    mem_read_data;
    logic          mem_read_ack;

    cpu_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .queue_level    (queue_level),
        .timer_cpu_tick (timer_cpu_tick),
        .mem_read       (mem_read),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_read_ack   (mem_read_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Memory with programmable ack latency (1 = ack in the first request cycle).
    logic [7:0] mem [4096];
    int lat = 1;
    int lat_cnt;

    always_comb begin
        mem_read_ack  = mem_read && (lat_cnt >= lat - 1);
        mem_read_data = mem_read_ack ? mem[mem_read_addr] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst || !mem_read || mem_read_ack) lat_cnt <= 0;
        else                                  lat_cnt <= lat_cnt + 1;
    end

    // Tick source: constant high, or one pulse every 10 cycles.
    logic periodic = 1'b0;
    int   phase = 0;
    always begin
        @(posedge clk);
        #1;
        phase          = (phase == 9) ? 0 : phase + 1;
        timer_cpu_tick = periodic ? (phase == 0) : 1'b1;
    end

    // Stream model and protocol monitor, sampled at the falling edge.
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] nxt_pc;
    logic          expect_empty = 1'b0;
    logic          prev_rd = 1'b0;
    logic          prev_ack = 1'b0;
    logic [AW-1:0] prev_addr;
    int            hs_cnt = 0;
    int            rd_cnt = 0;
    int            cnt_204 = 0;
    fetch_entry_t  hs_q[$];
    logic [AW-1:0] addr_q[$];

    always begin
        fetch_entry_t e;
        @(negedge clk);
        if (rst) begin
            exp_pc       = 12'h200;
            expect_empty = 1'b0;
            prev_rd      = 1'b0;
            prev_ack     = 1'b0;
        end else begin
            if (expect_empty) chk("flush_valid", 32'(instr_valid), 32'd0);
            expect_empty = 1'b0;
            if (instr_valid) begin
                nxt_pc = exp_pc + 12'd1;
                chk("head_pc", 32'(instr_pc), 32'(exp_pc));
                chk("head_instr", 32'(instr), 32'({mem[exp_pc], mem[nxt_pc]}));
                if (instr_pc == 12'h204) cnt_204++;
                if (instr_ready) begin
                    e.pc    = instr_pc;
                    e.instr = instr;
                    hs_q.push_back(e);
                    hs_cnt++;
                    exp_pc = exp_pc + 12'd2;
                end
            end
            if (!periodic) chk("valid_vs_level", 32'(instr_valid), 32'(queue_level != 3'd0));
            if (queue_level > 3'd4) chk("level_max", 32'(queue_level), 32'd4);
            if (prev_rd && !prev_ack) begin
                chk("rd_hold", 32'(mem_read), 32'd1);
                chk("addr_hold", 32'(mem_read_addr), 32'(prev_addr));
            end
            if (mem_read && mem_read_ack) begin
                rd_cnt++;
                addr_q.push_back(mem_read_addr);
            end
            if (redirect) begin
                exp_pc       = redirect_pc;
                expect_empty = 1'b1;
            end
            prev_rd   = mem_read;
            prev_ack  = mem_read_ack;
            prev_addr = mem_read_addr;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        cycles(1);
        redirect    = 1'b0;
    endtask

    initial begin
        int base;
        int base_hs;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem['h200] = 8'h12; mem['h201] = 8'h34; mem['h202] = 8'h56; mem['h203] = 8'h78;
        mem['h300] = 8'hA5; mem['h301] = 8'h5A;
        mem['hFFF] = 8'hAB; mem['h000] = 8'hCD; mem['h001] = 8'hEF; mem['h002] = 8'h01;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        cycles(3);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_addr", 32'(mem_read_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_level", 32'(queue_level), 32'd0);
        rst = 1'b0;

        // First two instructions from the reset PC with zero-wait memory.
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && hs_cnt < 2; i++) cycles(1);
        chk("first_hs_count", 32'(hs_cnt >= 2), 32'd1);
        if (hs_q.size() >= 2 && addr_q.size() >= 4) begin
            chk("hs0_pc", 32'(hs_q[0].pc), 32'h200);
            chk("hs0_instr", 32'(hs_q[0].instr), 32'h1234);
            chk("hs1_pc", 32'(hs_q[1].pc), 32'h202);
            chk("hs1_instr", 32'(hs_q[1].instr), 32'h5678);
            for (int i = 0; i < 4; i++) chk("addr_seq", 32'(addr_q[i]), 32'h200 + 32'(i));
        end

        // Back-pressure fills the queue, then a single pop triggers exactly one refill.
        instr_ready = 1'b0;
        for (int i = 0; i < 100 && queue_level != 3'd4; i++) cycles(1);
        chk("fill_level", 32'(queue_level), 32'd4);
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            chk("full_no_read", 32'(mem_read), 32'd0);
        end
        base = rd_cnt;
        instr_ready = 1'b1;
        cycles(1);
        instr_ready = 1'b0;
        cycles(20);
        chk("refill_reads", 32'(rd_cnt - base), 32'd2);
        chk("refill_level", 32'(queue_level), 32'd4);

        // Redirect during a slow read of 'h205: drain, discard, restart at 'h300.
        lat = 5;
        base = cnt_204;
        pulse_redirect(12'h204);
        for (int i = 0; i < 60 && !(mem_read && mem_read_addr == 12'h205); i++) cycles(1);
        chk("saw_read_205", 32'(mem_read_addr), 32'h205);
        cycles(2);
        instr_ready = 1'b1;
        pulse_redirect(12'h300);
        chk("drain_mem_read", 32'(mem_read), 32'd1);
        base_hs = rd_cnt;
        for (int i = 0; i < 20 && rd_cnt == base_hs; i++) cycles(1);
        chk("drain_ack_seen", 32'(rd_cnt - base_hs), 32'd1);
        if (addr_q.size() > 0) chk("drain_addr", 32'(addr_q[$]), 32'h205);
        for (int i = 0; i < 20 && !mem_read; i++) cycles(1);
        chk("post_drain_addr", 32'(mem_read_addr), 32'h300);
        base_hs = hs_cnt;
        for (int i = 0; i < 60 && hs_cnt == base_hs; i++) cycles(1);
        chk("hs300_count", 32'(hs_cnt - base_hs), 32'd1);
        if (hs_q.size() > base_hs) begin
            chk("hs300_pc", 32'(hs_q[base_hs].pc), 32'h300);
            chk("hs300_instr", 32'(hs_q[base_hs].instr), 32'hA55A);
        end
        chk("no_204_entry", 32'(cnt_204 - base), 32'd0);

        // Address wrap from 'hFFF.
        lat = 1;
        pulse_redirect(12'hFFF);
        base_hs = hs_cnt;
        for (int i = 0; i < 80 && hs_cnt < base_hs + 2; i++) cycles(1);
        chk("wrap_hs_count", 32'(hs_cnt - base_hs >= 2), 32'd1);
        if (hs_q.size() >= base_hs + 2) begin
            chk("wrap_pc0", 32'(hs_q[base_hs].pc), 32'hFFF);
            chk("wrap_instr0", 32'(hs_q[base_hs].instr), 32'hABCD);
            chk("wrap_pc1", 32'(hs_q[base_hs + 1].pc), 32'h001);
            chk("wrap_instr1", 32'(hs_q[base_hs + 1].instr), 32'hEF01);
        end

        // Redirect and handshake together at level 3.
        instr_ready = 1'b0;
        pulse_redirect(12'h400);
        for (int i = 0; i < 60 && queue_level != 3'd3; i++) cycles(1);
        chk("lvl3_reached", 32'(queue_level), 32'd3);
        instr_ready = 1'b1;
        pulse_redirect(12'h500);
        chk("redir_hs_level", 32'(queue_level), 32'd0);
        chk("redir_hs_valid", 32'(instr_valid), 32'd0);
        cycles(30);

`ifdef FETCH_TICK_THROTTLE_EN
        // One hand-over per tick period once the queue is primed.
        periodic = 1'b1;
        cycles(20);
        for (int p = 0; p < 5; p++) begin
            base_hs = hs_cnt;
            cycles(10);
            chk("hs_per_tick", 32'(hs_cnt - base_hs), 32'd1);
        end
        periodic = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
